// File: rtl/prog_clock_gen.sv
// prog_clock_gen: multi-channel programmable clock generator.
// Each channel divides the reference clock with a run-time programmable
// period P, high time H and start phase D, all counted in clk cycles.
// A reconfiguration of a running channel is held in a shadow register and
// takes effect at the next period boundary, so the output never glitches.
// Ports:
//   clk, rst_n           reference clock, async active-low reset
//   cfg_valid/cfg_ready  config write handshake (cfg_ready combinational)
//   cfg_ch               target channel of the write
//   cfg_period/high/phase  P, H, D of the write
//   ch_en                per-channel run enable
//   clk_out              generated clocks (registered)
//   ch_active            per-channel "not idle" flag (registered)
//   cfg_err              one-cycle pulse after a rejected write
module prog_clock_gen #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ch_active,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  state_t           r_state [NUM_CH];
  logic [CNT_W-1:0] r_cnt   [NUM_CH];
  cfg_t             r_act   [NUM_CH];
  cfg_t             r_shd   [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_active;
  logic              r_err;

  state_t           w_state_nxt [NUM_CH];
  logic [CNT_W-1:0] w_cnt_nxt   [NUM_CH];
  cfg_t             w_act_nxt   [NUM_CH];
  cfg_t             w_shd_nxt   [NUM_CH];
  logic [NUM_CH-1:0] w_pend_nxt;
  logic [NUM_CH-1:0] w_clk_nxt;
  logic [NUM_CH-1:0] w_active_nxt;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_wrap;
  logic              w_err_nxt;
  logic              w_sel_pend;
  logic              w_ch_ok;
  logic              w_legal;
  logic              w_wr_acc;
  logic              w_wr_ok;
  cfg_t              w_cfg_in;

  // Write decode: legality of the incoming config and handshake
  always_comb begin
    w_sel_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) w_sel_pend = r_pend[i];
    end
    // Out-of-range channels never match above, so they are always ready
    cfg_ready = rst_n && !w_sel_pend;
    w_ch_ok   = (32'(cfg_ch) < NUM_CH);
    w_legal   = w_ch_ok && (cfg_period >= CNT_W'(2)) && (cfg_high != '0) &&
                (cfg_high <= cfg_period - CNT_W'(1)) &&
                (cfg_phase <= cfg_period - CNT_W'(1));
    w_wr_acc  = cfg_valid && cfg_ready;
    w_wr_ok   = w_wr_acc && w_legal;
    w_err_nxt = w_wr_acc && !w_legal;
    w_cfg_in.period = cfg_period;
    w_cfg_in.high   = cfg_high;
    w_cfg_in.phase  = cfg_phase;
  end

  // Per-channel next-state, counter, output and config update
  always_comb begin
    w_pend_nxt   = r_pend;
    w_clk_nxt    = '0;
    w_active_nxt = '0;
    w_sel        = '0;
    w_wrap       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_act_nxt[i]   = r_act[i];
      w_shd_nxt[i]   = r_shd[i];
      w_sel[i]  = w_wr_ok && (cfg_ch == CH_W'(i));
      w_wrap[i] = (r_state[i] == ST_RUN) &&
                  (r_cnt[i] == r_act[i].period - CNT_W'(1));
      unique case (r_state[i])
        ST_IDLE: begin
          if (ch_en[i]) begin
            if (r_act[i].phase == '0) begin
              w_state_nxt[i] = ST_RUN;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_state_nxt[i] = ST_PHASE;
              w_cnt_nxt[i]   = r_act[i].phase - CNT_W'(1);
            end
          end
        end
        ST_PHASE: begin
          if (!ch_en[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end else if (r_cnt[i] == '0) begin
            w_state_nxt[i] = ST_RUN;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
          end
        end
        ST_RUN: begin
          w_clk_nxt[i] = (r_cnt[i] < r_act[i].high);
          if (w_wrap[i]) begin
            w_cnt_nxt[i] = '0;
            // A stop request only takes effect once the period is complete
            if (!ch_en[i]) w_state_nxt[i] = ST_IDLE;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
        end
      endcase
      // Shadow commits on a wrap only if it was pending before this edge
      if (w_wrap[i] && r_pend[i]) begin
        w_act_nxt[i]  = r_shd[i];
        w_pend_nxt[i] = 1'b0;
      end
      if (w_sel[i]) begin
        if (r_state[i] == ST_IDLE) begin
          w_act_nxt[i] = w_cfg_in;
        end else begin
          w_shd_nxt[i]  = w_cfg_in;
          w_pend_nxt[i] = 1'b1;
        end
      end
      w_active_nxt[i] = (w_state_nxt[i] != ST_IDLE);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]        <= ST_IDLE;
        r_cnt[i]          <= '0;
        r_act[i].period   <= CNT_W'(2);
        r_act[i].high     <= CNT_W'(1);
        r_act[i].phase    <= '0;
        r_shd[i]          <= '0;
      end
      r_pend   <= '0;
      r_clk    <= '0;
      r_active <= '0;
      r_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_act[i]   <= w_act_nxt[i];
        r_shd[i]   <= w_shd_nxt[i];
      end
      r_pend   <= w_pend_nxt;
      r_clk    <= w_clk_nxt;
      r_active <= w_active_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign clk_out   = r_clk;
  assign ch_active = r_active;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_prog_clock_gen.sv
// Bench for prog_clock_gen: directed scenarios followed by random traffic,
// checked cycle by cycle against a time-based reference model.
module tb_prog_clock_gen;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [CNT_W-1:0]  cfg_high = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] ch_active;
  logic              cfg_err;

  prog_clock_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
    .cfg_phase(cfg_phase), .ch_en(ch_en), .clk_out(clk_out),
    .ch_active(ch_active), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] act;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a running channel is described by the edge index at
  // which its current period's first output sample appears (pstart).
  longint m_k;
  bit     m_arm  [NUM_CH];
  longint m_pst  [NUM_CH];
  int     m_p    [NUM_CH];
  int     m_h    [NUM_CH];
  int     m_d    [NUM_CH];
  int     s_p    [NUM_CH];
  int     s_h    [NUM_CH];
  int     s_d    [NUM_CH];
  bit     m_pend [NUM_CH];

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_arm[i] = 1'b0; m_pend[i] = 1'b0; m_pst[i] = 0;
      m_p[i] = 2; m_h[i] = 1; m_d[i] = 0;
      s_p[i] = 0; s_h[i] = 0; s_d[i] = 0;
    end
  endtask

  function automatic bit model_ready(input int ch);
    if (ch >= NUM_CH) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_step(input bit v, input int ch, input int p, input int h,
                            input int d, input logic [NUM_CH-1:0] en,
                            output exp_t e);
    bit     was_arm [NUM_CH];
    bit     acc, legal;
    longint j;
    acc   = v && model_ready(ch);
    legal = (ch < NUM_CH) && (p >= 2) && (h >= 1) && (h <= p - 1) && (d <= p - 1);
    e.clk = '0;
    e.act = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      was_arm[i] = m_arm[i];
      if (!m_arm[i]) begin
        if (en[i]) begin
          m_arm[i] = 1'b1;
          m_pst[i] = m_k + longint'(m_d[i]) + 1;
        end
      end else if (m_k < m_pst[i]) begin
        if (!en[i]) m_arm[i] = 1'b0;
      end else begin
        j = m_k - m_pst[i];
        e.clk[i] = (j < longint'(m_h[i]));
        if (j == longint'(m_p[i] - 1)) begin
          if (m_pend[i]) begin
            m_p[i] = s_p[i]; m_h[i] = s_h[i]; m_d[i] = s_d[i];
            m_pend[i] = 1'b0;
          end
          if (!en[i]) m_arm[i] = 1'b0;
          else        m_pst[i] = m_k + 1;
        end
      end
      e.act[i] = m_arm[i];
    end
    if (acc && legal) begin
      if (!was_arm[ch]) begin
        m_p[ch] = p; m_h[ch] = h; m_d[ch] = d;
      end else begin
        s_p[ch] = p; s_h[ch] = h; s_d[ch] = d;
        m_pend[ch] = 1'b1;
      end
    end
    e.err = acc && !legal;
    m_k++;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One reference cycle: drive inputs after the falling edge, check the
  // combinational ready, then queue what the next rising edge must produce.
  task automatic cycle(input bit v, input int ch, input int p, input int h,
                       input int d, input logic [NUM_CH-1:0] en);
    exp_t e;
    @(negedge clk);
    cfg_valid  = v;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_phase  = CNT_W'(d);
    ch_en      = en;
    #1;
    check("cfg_ready", longint'(cfg_ready), longint'(model_ready(ch)));
    model_step(v, ch, p, h, d, en, e);
    last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [NUM_CH-1:0] en);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0, en);
  endtask

  // Ends on a falling edge where reset is released; that cycle is modelled
  task automatic release_reset();
    exp_t e;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_ch = '0; ch_en = '0;
    rst_n = 1'b1;
    model_reset();
    #1;
    check("cfg_ready_rel", longint'(cfg_ready), 1);
    model_step(1'b0, 0, 0, 0, 0, '0, e);
    last_exp = e;
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge compare the DUT against the queued model
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("clk_out",   longint'(clk_out),   longint'(e.clk));
        check("ch_active", longint'(ch_active), longint'(e.act));
        check("cfg_err",   longint'(cfg_err),   longint'(e.err));
      end
    end
  end

  initial begin
    int  waited;
    logic [NUM_CH-1:0] en;
    m_k = 0;
    model_reset();
    #3;
    check("cfg_ready_rst", longint'(cfg_ready), 0);
    check("clk_out_rst",   longint'(clk_out), 0);
    check("ch_active_rst", longint'(ch_active), 0);
    check("cfg_err_rst",   longint'(cfg_err), 0);
    repeat (2) @(posedge clk);
    release_reset();
    idle(2, 3'b000);

    // Basic 10/4 with no phase
    cycle(1'b1, 0, 10, 4, 0, 3'b000);
    idle(25, 3'b001);
    // Stop ch0, program ch1 8/4/3, then start both on one edge
    idle(12, 3'b000);
    cycle(1'b1, 1, 8, 4, 3, 3'b000);
    idle(30, 3'b011);
    // Mid-period reconfiguration plus a write that must see ready low
    cycle(1'b1, 0, 6, 3, 0, 3'b011);
    cycle(1'b1, 0, 7, 2, 0, 3'b011);
    idle(25, 3'b011);
    // Illegal writes
    cycle(1'b1, 0, 8, 0, 0, 3'b011); idle(1, 3'b011);
    cycle(1'b1, 0, 8, 8, 0, 3'b011); idle(1, 3'b011);
    cycle(1'b1, 0, 1, 1, 0, 3'b011); idle(1, 3'b011);
    cycle(1'b1, 1, 8, 4, 8, 3'b011); idle(1, 3'b011);
    cycle(1'b1, 3, 8, 4, 0, 3'b011); idle(1, 3'b011);
    // Back to 10/4 on ch0, then stop at cnt=1, re-raise, stop for good
    cycle(1'b1, 0, 10, 4, 0, 3'b011);
    idle(20, 3'b011);
    waited = 0;
    while (!(m_arm[0] && m_k >= m_pst[0] && (m_k - m_pst[0]) == 1) && waited < 30) begin
      idle(1, 3'b011);
      waited++;
    end
    check("sync_cnt1", longint'(waited < 30), 1);
    idle(3, 3'b010);
    idle(12, 3'b011);
    idle(14, 3'b010);

    // Asynchronous reset in the middle of a high phase
    idle(1, 3'b001);
    waited = 0;
    while (!last_exp.clk[0] && waited < 30) begin
      idle(1, 3'b001);
      waited++;
    end
    check("sync_high", longint'(waited < 30), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("clk_out_async",   longint'(clk_out), 0);
    check("ch_active_async", longint'(ch_active), 0);
    check("cfg_ready_async", longint'(cfg_ready), 0);
    repeat (2) @(posedge clk);
    release_reset();
    idle(12, 3'b001);

    // Random traffic
    en = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      int p, h, d;
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
      p = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, p + 1));
      d = int'($urandom_range(0, p));
      cycle($urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), p, h, d, en);
    end
    idle(2, 3'b000);
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
